// File: rtl/fp_pkg.sv
// fp_pkg
// Shared constants and helpers for the floating-point operand path
// (int_to_floating_converter producer and floating_point_addition consumer).
//   - width/bias constants for IEEE-754 single precision
//   - converter FSM state enum
//   - packed-float field-slice helpers {sign, exponent, mantissa}
package fp_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int MENT_WIDTH = 23;
   localparam int EXPO_WIDTH = 8;
   localparam int EXPO_BIAS  = 127;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_HOLD  = 2'd3
   } conv_state_e;

   function automatic logic fp_sign(input logic [DATA_WIDTH-1:0] f);
      return f[DATA_WIDTH-1];
   endfunction

   function automatic logic [EXPO_WIDTH-1:0] fp_expo(input logic [DATA_WIDTH-1:0] f);
      return f[DATA_WIDTH-2 -: EXPO_WIDTH];
   endfunction

   function automatic logic [MENT_WIDTH-1:0] fp_ment(input logic [DATA_WIDTH-1:0] f);
      return f[MENT_WIDTH-1:0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] fp_pack(input logic s,
                                                     input logic [EXPO_WIDTH-1:0] e,
                                                     input logic [MENT_WIDTH-1:0] m);
      return {s, e, m};
   endfunction

endpackage

// File: rtl/fp_round_nearest_even.sv
// fp_round_nearest_even
// Combinational round-to-nearest-even of a truncated mantissa.
//   ment_in     : kept mantissa bits (hidden bit excluded)
//   guard_in    : first discarded bit
//   sticky_in   : OR of all remaining discarded bits
//   ment_out    : rounded mantissa (wraps to 0 on carry)
//   carry_out   : increment overflowed the mantissa; caller bumps exponent
//   inexact_out : any discarded bit was nonzero
module fp_round_nearest_even
   import fp_pkg::*;
#(
   parameter int MENT_WIDTH = fp_pkg::MENT_WIDTH
) (
   input  logic [MENT_WIDTH-1:0] ment_in,
   input  logic                  guard_in,
   input  logic                  sticky_in,
   output logic [MENT_WIDTH-1:0] ment_out,
   output logic                  carry_out,
   output logic                  inexact_out
);

   logic round_up;

   // Above half rounds up; exactly half rounds up only when LSB is odd.
   assign round_up    = guard_in & (sticky_in | ment_in[0]);
   assign {carry_out, ment_out} = {1'b0, ment_in} + {{MENT_WIDTH{1'b0}}, round_up};
   assign inexact_out = guard_in | sticky_in;

endmodule

// File: rtl/int_to_floating_converter.sv
// int_to_floating_converter
// Multi-cycle signed integer -> IEEE-754 single converter, producer of the
// floating-point operand stream. One conversion in flight at a time.
//   clk_in, rstn_in          : clock, async active-low reset
//   int_valid_in/ready_out   : integer input handshake (ready only in IDLE)
//   int_data_in              : two's-complement integer
//   float_valid_out/ready_in : result handshake (valid only in HOLD)
//   floating_out             : {sign, exponent, mantissa}
//   inexact_out              : result was rounded, qualified by float_valid_out
module int_to_floating_converter #(
   parameter int DATA_WIDTH = fp_pkg::DATA_WIDTH,
   parameter int MENT_WIDTH = fp_pkg::MENT_WIDTH,
   parameter int EXPO_WIDTH = fp_pkg::EXPO_WIDTH,
   parameter int INT_WIDTH  = 32,
   parameter int EXPO_BIAS  = fp_pkg::EXPO_BIAS
) (
   input  logic                  clk_in,
   input  logic                  rstn_in,
   input  logic                  int_valid_in,
   output logic                  int_ready_out,
   input  logic [INT_WIDTH-1:0]  int_data_in,
   output logic                  float_valid_out,
   input  logic                  float_ready_in,
   output logic [DATA_WIDTH-1:0] floating_out,
   output logic                  inexact_out
);

   import fp_pkg::*;

   localparam int XW  = EXPO_WIDTH + 1;
   // Bit index of the guard bit once the leading one sits at the MSB.
   localparam int GRD = INT_WIDTH - 2 - MENT_WIDTH;
   localparam logic [XW-1:0] EXPO_INIT = XW'(EXPO_BIAS + INT_WIDTH - 1);

   conv_state_e           state_q, state_d;
   logic                  sign_q, sign_d;
   logic [INT_WIDTH-1:0]  mag_q, mag_d;
   logic [XW-1:0]         expo_q, expo_d;
   logic [DATA_WIDTH-1:0] float_q, float_d;
   logic                  inexact_q, inexact_d;

   logic [MENT_WIDTH-1:0] rnd_ment;
   logic                  rnd_carry;
   logic                  rnd_inexact;
   logic [XW-1:0]         expo_rnd;

   // Leading one is implicit; mantissa is the bits just below the MSB.
   fp_round_nearest_even #(.MENT_WIDTH(MENT_WIDTH)) u_round (
      .ment_in     (mag_q[INT_WIDTH-2 -: MENT_WIDTH]),
      .guard_in    (mag_q[GRD]),
      .sticky_in   (|mag_q[GRD-1:0]),
      .ment_out    (rnd_ment),
      .carry_out   (rnd_carry),
      .inexact_out (rnd_inexact)
   );

   assign expo_rnd = expo_q + {{(XW-1){1'b0}}, rnd_carry};

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      mag_d     = mag_q;
      expo_d    = expo_q;
      float_d   = float_q;
      inexact_d = inexact_q;
      case (state_q)
         ST_IDLE: begin
            if (int_valid_in) begin
               sign_d = int_data_in[INT_WIDTH-1];
               // Most negative value negates to itself, which is the correct
               // unsigned magnitude 2^(INT_WIDTH-1).
               mag_d  = int_data_in[INT_WIDTH-1] ? (~int_data_in + 1'b1) : int_data_in;
               expo_d = EXPO_INIT;
               if (int_data_in == '0) begin
                  sign_d    = 1'b0;
                  float_d   = '0;
                  inexact_d = 1'b0;
                  state_d   = ST_HOLD;
               end else begin
                  state_d = ST_NORM;
               end
            end
         end
         ST_NORM: begin
            if (mag_q[INT_WIDTH-1]) begin
               state_d = ST_ROUND;
            end else begin
               mag_d  = mag_q << 1;
               expo_d = expo_q - 1'b1;
            end
         end
         ST_ROUND: begin
            float_d   = {sign_q, expo_rnd[EXPO_WIDTH-1:0], rnd_ment};
            inexact_d = rnd_inexact;
            state_d   = ST_HOLD;
         end
         ST_HOLD: begin
            if (float_ready_in) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q   <= ST_IDLE;
         sign_q    <= 1'b0;
         mag_q     <= '0;
         expo_q    <= '0;
         float_q   <= '0;
         inexact_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         mag_q     <= mag_d;
         expo_q    <= expo_d;
         float_q   <= float_d;
         inexact_q <= inexact_d;
      end
   end

   // Handshake flags decode from registered state only.
   assign int_ready_out   = (state_q == ST_IDLE);
   assign float_valid_out = (state_q == ST_HOLD);
   assign floating_out    = float_q;
   assign inexact_out     = inexact_q;

endmodule
